cnn_conv_engine: RTL and testbench
==================================

Name: cnn_conv_engine

Overview:
Sequential, parametrised successor to the ALU's combinational weight-capture and convolution path. It loads an IN_DIM×IN_DIM feature tile and a K_DIM×K_DIM kernel through a valid/ready beat interface, then computes the valid 2-D convolution with one time-multiplexed MAC. Optional ReLU on inputs and magnitude pruning on kernel weights are selectable per run. Results come out as one packed, saturated word under a valid/ack handshake. The engine sits beside the ALU and is driven by custom-opcode load/read instructions.

Parameters:
DATA_W, 8, element width (signed two's complement) for inputs, weights and outputs
IN_DIM, 4, input tile side
K_DIM, 3, kernel side; OUT_DIM = IN_DIM-K_DIM+1 (must be ≥1)
ACC_W, 2*DATA_W+$clog2(K_DIM*K_DIM)+1, accumulator width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
load_valid  in  1  load beat valid
load_ready  out  1  engine accepts a load beat
load_data  in  2*DATA_W  two elements per beat: [2*DATA_W-1:DATA_W] first, [DATA_W-1:0] second
mode  in  2  bit0 = ReLU inputs, bit1 = prune kernel; sampled on the final load beat
prune_thr  in  DATA_W  unsigned threshold; sampled with mode
clear  in  1  synchronous abort to LOAD
result_valid  out  1  result holds a finished tile
result_ack  in  1  consumer takes the result
result  out  OUT_DIM*OUT_DIM*DATA_W  packed outputs, element (0,0) in the MSBs, row-major
busy  out  1  high in COMPUTE

Behaviour:
- Reset (rst=0, asynchronous): state=LOAD. Beat counter, MAC indices, accumulator, result and result_valid are 0. busy=0. load_ready=1 once rst deasserts.
- Element order: NE = IN_DIM²+K_DIM² (default 25). Input tile row-major first, then kernel row-major. BEATS = ceil(NE/2) (default 13). The second element of the final beat is ignored when NE is odd.
- LOAD: load_ready=1. Each beat with load_valid&load_ready writes two elements and increments the beat counter. The beat with counter=BEATS-1 latches mode and prune_thr, then moves to COMPUTE on the next edge. load_valid while load_ready=0 is ignored; no beat is lost or double-counted.
- Preprocessing, applied on operand read in COMPUTE:
  - ReLU: a negative input is treated as 0.
  - Prune: a weight with |w| < prune_thr is treated as 0. |−2^(DATA_W−1)| is taken as 2^(DATA_W−1).
- COMPUTE: one signed DATA_W×DATA_W product per cycle, accumulated in ACC_W bits.
  - Loop order: output row, output column, kernel row, kernel column.
  - After the last kernel tap of each output, the accumulator saturates to the signed DATA_W range [−2^(DATA_W−1), 2^(DATA_W−1)−1], is written into its result slot, and is cleared.
  - Duration is OUT_DIM²·K_DIM² cycles (default 36). On the last cycle, state→DONE.
- DONE: result_valid=1 and result stays stable.
  - result_ack=1 drops result_valid on the next edge, clears the beat counter, state→LOAD. result is held until it is overwritten by the next tile.
  - load_ready=0 in COMPUTE and DONE.
- Latency: result_valid rises exactly OUT_DIM²·K_DIM²+1 edges after the edge that accepted the final beat (37 by default).
- clear: in any state, clear=1 returns the engine to LOAD on the next edge and zeroes the counters, accumulator and result_valid. clear takes priority over load and ack in the same cycle. A beat presented with clear is not accepted.
- Simultaneous events:
  - result_ack outside DONE is ignored.
  - mode and prune_thr changes outside the final beat have no effect on the run in progress.
- Reset mid-operation: returns to the reset state immediately. Partial tiles are discarded.

Test Plan:
- Mode 00, all 25 elements = 1 (13 beats of 0x0101) → after 37 cycles result=0x09090909, result_valid=1, load_ready=0.
- Mode 01, input row 0 all −1 (0xFF), other inputs 1, kernel all 1 → results (0,0),(0,1) = 6, (1,*) = 9 → 0x06060909. Same data in mode 00 → 0x03030909.
- Mode 10, prune_thr=2, kernel {1,1,1,1,3,1,1,1,1}, inputs all 2 → only centre tap survives → 0x06060606.
- Saturation: inputs and weights all 127 → 0x7F7F7F7F. Weights all −128 with inputs 127 → 0x80808080.
- Backpressure and ack: hold result_ack=0 for 10 cycles while driving load_valid=1 → result stable, no beats accepted. Pulse ack → result_valid=0 next edge, load_ready=1, a new tile loads.
- Abort: assert clear at COMPUTE cycle 20 → LOAD next edge, result_valid never rises. Separately, assert rst=0 asynchronously mid-LOAD → outputs zero without a clock edge, and the next full load gives the correct result.

Source files
------------

// File: rtl/cnn_conv_engine.sv
// Sequential valid-mode 2-D convolution engine: beat-wise tile/kernel load,
// one time-multiplexed MAC, optional input ReLU and kernel pruning, saturated packed result.
module cnn_conv_engine #(
  parameter int DATA_W = 8,
  parameter int IN_DIM = 4,
  parameter int K_DIM  = 3,
  parameter int ACC_W  = 2*DATA_W + $clog2(K_DIM*K_DIM) + 1
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    load_valid,
  output logic                                                    load_ready,
  input  logic [2*DATA_W-1:0]                                     load_data,
  input  logic [1:0]                                              mode,
  input  logic [DATA_W-1:0]                                       prune_thr,
  input  logic                                                    clear,
  output logic                                                    result_valid,
  input  logic                                                    result_ack,
  output logic [(IN_DIM-K_DIM+1)*(IN_DIM-K_DIM+1)*DATA_W-1:0]     result,
  output logic                                                    busy
);

  localparam int OUT_DIM = IN_DIM - K_DIM + 1;
  localparam int OUT_N   = OUT_DIM * OUT_DIM;
  localparam int IN_N    = IN_DIM * IN_DIM;
  localparam int NE      = IN_N + K_DIM * K_DIM;
  localparam int BEATS   = (NE + 1) / 2;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ADDR_W  = BEAT_W + 1;
  localparam int O_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int K_W     = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int OUT_AW  = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  localparam logic [BEAT_W-1:0]       BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [O_W-1:0]          O_LAST    = O_W'(OUT_DIM - 1);
  localparam logic [K_W-1:0]          K_LAST    = K_W'(K_DIM - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2**(DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DONE} state_t;

  state_t                     state;
  logic [BEAT_W-1:0]          beat_cnt;
  logic [O_W-1:0]             orow, ocol;
  logic [K_W-1:0]             krow, kcol;
  logic signed [ACC_W-1:0]    acc_q;
  logic [1:0]                 mode_q;
  logic [DATA_W-1:0]          thr_q;
  logic [DATA_W-1:0]          res_q [OUT_N];
  logic signed [DATA_W-1:0]   elem_q [2*BEATS];

  logic [ADDR_W-1:0]          in_addr, w_addr;
  logic [OUT_AW-1:0]          out_idx;
  logic signed [DATA_W-1:0]   x_op, w_op;
  logic signed [DATA_W:0]     w_ext;
  logic [DATA_W:0]            w_mag;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sum;
  logic [DATA_W-1:0]          sat;
  logic                       tap_last, out_last;

  assign load_ready = (state == S_LOAD);
  assign busy       = (state == S_COMPUTE);

  // NOTE: the element buffer is plain storage overwritten on every load, so it
  // carries no reset; only control state and visible outputs are reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && load_valid && !clear) begin
      elem_q[{beat_cnt, 1'b0}] <= load_data[2*DATA_W-1:DATA_W];
      elem_q[{beat_cnt, 1'b1}] <= load_data[DATA_W-1:0];
    end
  end

  assign in_addr = ADDR_W'((int'(orow) + int'(krow)) * IN_DIM + int'(ocol) + int'(kcol));
  assign w_addr  = ADDR_W'(IN_N + int'(krow) * K_DIM + int'(kcol));
  assign out_idx = OUT_AW'(int'(orow) * OUT_DIM + int'(ocol));

  // Operand preprocessing happens on read so the stored tile stays untouched.
  // |w| is formed one bit wider so the most negative weight keeps its magnitude.
  always_comb begin
    x_op = elem_q[in_addr];
    if (mode_q[0] && x_op[DATA_W-1]) x_op = '0;
    w_op  = elem_q[w_addr];
    w_ext = {w_op[DATA_W-1], w_op};
    w_mag = w_op[DATA_W-1] ? unsigned'(-w_ext) : unsigned'(w_ext);
    if (mode_q[1] && (w_mag < {1'b0, thr_q})) w_op = '0;
  end

  assign prod    = (2*DATA_W)'(x_op) * (2*DATA_W)'(w_op);
  assign acc_sum = acc_q + ACC_W'(prod);

  always_comb begin
    if (acc_sum > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (acc_sum < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                        sat = acc_sum[DATA_W-1:0];
  end

  assign tap_last = (kcol == K_LAST) && (krow == K_LAST);
  assign out_last = tap_last && (ocol == O_LAST) && (orow == O_LAST);

  always_comb begin
    result = '0;
    for (int i = 0; i < OUT_N; i++) result[(OUT_N-1-i)*DATA_W +: DATA_W] = res_q[i];
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // updates from the values present before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_LOAD;
      beat_cnt     <= '0;
      orow         <= '0;
      ocol         <= '0;
      krow         <= '0;
      kcol         <= '0;
      acc_q        <= '0;
      mode_q       <= '0;
      thr_q        <= '0;
      result_valid <= 1'b0;
      for (int i = 0; i < OUT_N; i++) res_q[i] <= '0;
    end else if (clear) begin
      state        <= S_LOAD;
      beat_cnt     <= '0;
      orow         <= '0;
      ocol         <= '0;
      krow         <= '0;
      kcol         <= '0;
      acc_q        <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_valid) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (beat_cnt == BEAT_LAST) begin
              mode_q <= mode;
              thr_q  <= prune_thr;
              state  <= S_COMPUTE;
            end
          end
        end
        S_COMPUTE: begin
          if (tap_last) begin
            res_q[out_idx] <= sat;
            acc_q          <= '0;
          end else begin
            acc_q <= acc_sum;
          end
          if (kcol != K_LAST) begin
            kcol <= kcol + K_W'(1);
          end else begin
            kcol <= '0;
            if (krow != K_LAST) begin
              krow <= krow + K_W'(1);
            end else begin
              krow <= '0;
              if (ocol != O_LAST) begin
                ocol <= ocol + O_W'(1);
              end else begin
                ocol <= '0;
                orow <= (orow != O_LAST) ? orow + O_W'(1) : '0;
              end
            end
          end
          if (out_last) state <= S_DONE;
        end
        S_DONE: begin
          // The first DONE cycle publishes the tile; an ack only counts once it is visible.
          if (!result_valid) begin
            result_valid <= 1'b1;
          end else if (result_ack) begin
            result_valid <= 1'b0;
            beat_cnt     <= '0;
            state        <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Directed self-checking bench for cnn_conv_engine with the default 4x4 tile / 3x3 kernel.
module tb_cnn_conv_engine;

  localparam int DATA_W = 8;
  localparam int IN_DIM = 4;
  localparam int K_DIM  = 3;
  localparam int NE     = 25;
  localparam int BEATS  = 13;
  localparam int LAT    = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  prune_thr = '0;
  logic        clear = 1'b0;
  logic        result_valid;
  logic        result_ack = 1'b0;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] tile [NE];

  cnn_conv_engine #(.DATA_W(DATA_W), .IN_DIM(IN_DIM), .K_DIM(K_DIM)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .mode(mode), .prune_thr(prune_thr), .clear(clear),
    .result_valid(result_valid), .result_ack(result_ack), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic fill(input logic [7:0] in_v, input logic [7:0] k_v);
    for (int i = 0; i < 16; i++) tile[i] = in_v;
    for (int i = 16; i < NE; i++) tile[i] = k_v;
  endtask

  // Non-final beats carry inverted mode/threshold, which the engine must ignore.
  task automatic send_tile(input logic [1:0] m, input logic [7:0] thr, input int nb);
    for (int b = 0; b < nb; b++) begin
      int guard = 0;
      @(negedge clk);
      while (!load_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      load_valid = 1'b1;
      load_data  = {tile[2*b], (2*b+1 < NE) ? tile[2*b+1] : 8'hA5};
      mode       = (b == BEATS-1) ? m : ~m;
      prune_thr  = (b == BEATS-1) ? thr : ~thr;
      @(posedge clk);
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_result(input bit ack_during, output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (ack_during) result_ack = (c < 30);
      if (result_valid) begin
        lat = c;
        break;
      end
    end
    result_ack = 1'b0;
  endtask

  task automatic ack_result();
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
  endtask

  task automatic run_tile(input logic [1:0] m, input logic [7:0] thr, input bit ack_during,
                          output int lat, output logic [31:0] res, output logic rdy, output logic bsy);
    send_tile(m, thr, BEATS);
    wait_result(ack_during, lat);
    res = result;
    rdy = load_ready;
    bsy = busy;
    ack_result();
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({result_valid, busy, result} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b busy=%b result=%h expected 0/0/00000000", result_valid, busy, result);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_load_ready: got %b expected 1", load_ready);
    end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] res; logic rdy, bsy;
    fill(8'd1, 8'd1);
    run_tile(2'b00, 8'd0, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    n_checks++;
    if (res !== 32'h09090909) begin n_fail++; $display("FAIL basic_result: got %h expected 09090909", res); end
    n_checks++;
    if ({rdy, bsy} !== 2'b00) begin n_fail++; $display("FAIL basic_done_flags: got ready=%b busy=%b expected 0/0", rdy, bsy); end
  endtask

  task automatic test_relu();
    int lat; logic [31:0] res; logic rdy, bsy;
    fill(8'd1, 8'd1);
    for (int i = 0; i < 4; i++) tile[i] = 8'hFF;
    run_tile(2'b01, 8'd0, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (res !== 32'h06060909) begin n_fail++; $display("FAIL relu_on: got %h expected 06060909", res); end
    run_tile(2'b00, 8'd0, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (res !== 32'h03030909) begin n_fail++; $display("FAIL relu_off: got %h expected 03030909", res); end
  endtask

  task automatic test_prune();
    int lat; logic [31:0] res; logic rdy, bsy;
    fill(8'd2, 8'd1);
    tile[20] = 8'd3;
    run_tile(2'b10, 8'd2, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (res !== 32'h06060606) begin n_fail++; $display("FAIL prune_centre: got %h expected 06060606", res); end
    // Threshold 128: weights of 127 are pruned, -128 has magnitude 128 and survives.
    fill(8'd1, 8'd127);
    tile[20] = 8'h80;
    run_tile(2'b10, 8'h80, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (res !== 32'h80808080) begin n_fail++; $display("FAIL prune_min_weight: got %h expected 80808080", res); end
  endtask

  task automatic test_saturation();
    int lat; logic [31:0] res; logic rdy, bsy;
    fill(8'd127, 8'd127);
    run_tile(2'b00, 8'd0, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (res !== 32'h7F7F7F7F) begin n_fail++; $display("FAIL sat_positive: got %h expected 7f7f7f7f", res); end
    fill(8'd127, 8'h80);
    run_tile(2'b00, 8'd0, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (res !== 32'h80808080) begin n_fail++; $display("FAIL sat_negative: got %h expected 80808080", res); end
  endtask

  task automatic test_ack_ignored();
    int lat;
    fill(8'd1, 8'd1);
    send_tile(2'b00, 8'd0, BEATS);
    wait_result(1'b1, lat);
    n_checks++;
    if (lat !== LAT || result !== 32'h09090909) begin
      n_fail++;
      $display("FAIL ack_in_compute: got latency %0d result %h expected %0d 09090909", lat, result, LAT);
    end
    ack_result();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] res; logic rdy, bsy;
    bit ok;
    fill(8'd1, 8'd1);
    for (int i = 0; i < 4; i++) tile[i] = 8'hFF;
    send_tile(2'b01, 8'd0, BEATS);
    wait_result(1'b0, lat);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 16'h7F7F;
      @(posedge clk);
      #1;
      if (result !== 32'h06060909 || result_valid !== 1'b1 || load_ready !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hold_stable: got result=%h valid=%b ready=%b expected 06060909/1/0", result, result_valid, load_ready); end
    @(negedge clk);
    load_valid = 1'b0;
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    n_checks++;
    if ({result_valid, load_ready, result} !== {2'b01, 32'h06060909}) begin
      n_fail++;
      $display("FAIL ack_release: got valid=%b ready=%b result=%h expected 0/1/06060909", result_valid, load_ready, result);
    end
    fill(8'd1, 8'd1);
    for (int i = 0; i < 4; i++) tile[i] = 8'hFF;
    run_tile(2'b00, 8'd0, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (lat !== LAT || res !== 32'h03030909) begin
      n_fail++;
      $display("FAIL reload_after_hold: got latency %0d result %h expected %0d 03030909", lat, res, LAT);
    end
  endtask

  task automatic test_clear();
    int lat; logic [31:0] res; logic rdy, bsy;
    bit seen;
    fill(8'd2, 8'd1);
    send_tile(2'b00, 8'd0, BEATS);
    repeat (19) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, load_ready} !== 2'b10) begin n_fail++; $display("FAIL compute_flags: got busy=%b ready=%b expected 1/0", busy, load_ready); end
    @(negedge clk);
    clear = 1'b1;
    result_ack = 1'b1;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, load_ready} !== 2'b01) begin n_fail++; $display("FAIL clear_to_load: got busy=%b ready=%b expected 0/1", busy, load_ready); end
    @(negedge clk);
    clear = 1'b0;
    result_ack = 1'b0;
    load_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (result_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL clear_no_result: got result_valid=1 expected 0"); end
    // A beat offered together with clear must not be counted.
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'h7F7F;
    clear      = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    clear      = 1'b0;
    load_valid = 1'b0;
    run_tile(2'b00, 8'd0, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (lat !== LAT || res !== 32'h12121212) begin
      n_fail++;
      $display("FAIL load_after_clear: got latency %0d result %h expected %0d 12121212", lat, res, LAT);
    end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] res; logic rdy, bsy;
    fill(8'd1, 8'd1);
    send_tile(2'b00, 8'd0, 6);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({result_valid, busy, result} !== 34'h0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b busy=%b result=%h expected 0/0/00000000", result_valid, busy, result);
    end
    @(negedge clk);
    rst = 1'b1;
    fill(8'd2, 8'd1);
    run_tile(2'b01, 8'd0, 1'b0, lat, res, rdy, bsy);
    n_checks++;
    if (lat !== LAT || res !== 32'h12121212) begin
      n_fail++;
      $display("FAIL load_after_reset: got latency %0d result %h expected %0d 12121212", lat, res, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_prune();
    test_saturation();
    test_ack_ignored();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
